// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with start/ready handshake.
// add/sub/logic finish in one cycle; mul/div/mod iterate over N cycles.
module seq_alu #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [2:0]     op,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           zero,
  output logic           div_err
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [2*N-1:0] res_q, res_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;

  logic [N:0]     sum, dif, rsh;
  logic           qbit;
  logic [N-1:0]   rem_n, quo_n;
  logic [2*N-1:0] prod_n;
  logic [2*N-1:0] fres;
  logic           fc, fe, slow;

  // acc holds the partial product (mul) or partial remainder (div/mod);
  // y holds the multiplier bits or the dividend shifting into quotient.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    rsh    = {acc_q[N-1:0], y_q[N-1]};
    qbit   = rsh >= {1'b0, b_q};
    rem_n  = qbit ? N'(rsh - {1'b0, b_q}) : rsh[N-1:0];
    quo_n  = {y_q[N-2:0], qbit};
    prod_n = acc_q + (y_q[0] ? x_q : '0);

    fres = '0;
    fc   = 1'b0;
    fe   = 1'b0;
    slow = 1'b0;
    unique case (op)
      OP_ADD: begin
        fres = {{N{1'b0}}, sum[N-1:0]};
        fc   = sum[N];
      end
      OP_SUB: begin
        fres = {{N{1'b0}}, dif[N-1:0]};
        fc   = dif[N];
      end
      OP_MUL: slow = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          fres = {{N{1'b0}}, {N{1'b1}}};
          fe   = 1'b1;
        end else begin
          slow = 1'b1;
        end
      end
      OP_MOD: begin
        if (b == '0) begin
          fres = {{N{1'b0}}, a};
          fe   = 1'b1;
        end else begin
          slow = 1'b1;
        end
      end
      OP_AND: fres = {{N{1'b0}}, a & b};
      OP_OR:  fres = {{N{1'b0}}, a | b};
      OP_XOR: fres = {{N{1'b0}}, a ^ b};
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;

    unique case (state_q)
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = prod_n;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else begin
          acc_d = {{N{1'b0}}, rem_n};
          y_d   = quo_n;
        end
        if (cnt_q == CW'(N-1)) begin
          state_d = S_DONE;
          carry_d = 1'b0;
          err_d   = 1'b0;
          unique case (1'b1)
            (op_q == OP_MUL): res_d = prod_n;
            (op_q == OP_DIV): res_d = {{N{1'b0}}, quo_n};
            default:          res_d = {{N{1'b0}}, rem_n};
          endcase
          zero_d = (res_d == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          op_d  = op;
          b_d   = b;
          cnt_d = '0;
          acc_d = '0;
          x_d   = {{N{1'b0}}, a};
          if (slow) begin
            state_d = S_CALC;
            y_d     = (op == OP_MUL) ? b : a;
          end else begin
            state_d = S_DONE;
            res_d   = fres;
            carry_d = fc;
            err_d   = fe;
            zero_d  = (fres == '0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign ready   = (state_q != S_CALC);
  assign done    = (state_q == S_DONE);
  assign result  = res_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed stimulus for seq_alu, checked every
// cycle against a latency/arithmetic model of the ALU.
module tb_seq_alu;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic [2:0]   op;
  logic         ready, done, carry, zero, div_err;
  logic [W-1:0] result;

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .op(op),
    .ready(ready), .done(done), .result(result),
    .carry(carry), .zero(zero), .div_err(div_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         e;
    logic [7:0]   lat;
  } res_t;

  function automatic res_t calc_f(input logic [N-1:0] x,
                                  input logic [N-1:0] y,
                                  input logic [2:0] o);
    res_t t;
    int ua, ub, m, r;
    ua = int'(x);
    ub = int'(y);
    m  = 1 << N;
    r  = 0;
    t  = '0;
    t.lat = 8'd1;
    case (o)
      3'd0: begin r = (ua + ub) % m; t.c = (ua + ub) >= m; end
      3'd1: begin r = (ua - ub + m) % m; t.c = ua < ub; end
      3'd2: begin r = ua * ub; t.lat = 8'(N + 1); end
      3'd3: if (ub == 0) begin r = m - 1; t.e = 1'b1; end
            else begin r = ua / ub; t.lat = 8'(N + 1); end
      3'd4: if (ub == 0) begin r = ua; t.e = 1'b1; end
            else begin r = ua % ub; t.lat = 8'(N + 1); end
      3'd5: r = ua & ub;
      3'd6: r = ua | ub;
      default: r = ua ^ ub;
    endcase
    t.r = W'(r);
    return t;
  endfunction

  // Model: "left" counts edges until the pending answer appears.
  res_t         cur, pend;
  int           left   = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_res  = '0;
  logic         m_c = 1'b0, m_z = 1'b0, m_e = 1'b0;

  assign cur = calc_f(a, b, op);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left   <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_c    <= 1'b0;
      m_z    <= 1'b0;
      m_e    <= 1'b0;
    end else if (left != 0) begin
      left   <= left - 1;
      m_done <= (left == 1);
      if (left == 1) begin
        m_res <= pend.r;
        m_c   <= pend.c;
        m_e   <= pend.e;
        m_z   <= (pend.r == '0);
      end
    end else if (start) begin
      pend   <= cur;
      left   <= int'(cur.lat) - 1;
      m_done <= (cur.lat == 8'd1);
      if (cur.lat == 8'd1) begin
        m_res <= cur.r;
        m_c   <= cur.c;
        m_e   <= cur.e;
        m_z   <= (cur.r == '0);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready",   64'(ready),   64'(left == 0));
    chk("done",    64'(done),    64'(m_done));
    chk("result",  64'(result),  64'(m_res));
    chk("carry",   64'(carry),   64'(m_c));
    chk("zero",    64'(zero),    64'(m_z));
    chk("div_err", 64'(div_err), 64'(m_e));
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [2:0] o);
    start = 1'b1;
    a     = x;
    b     = y;
    op    = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go(input logic [N-1:0] x, input logic [N-1:0] y,
                    input logic [2:0] o);
    @(negedge clk);
    issue(x, y, o);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic expect_res(input string nm, input int lat, input int lat_x,
                            input logic [W-1:0] r, input logic c,
                            input logic z, input logic e);
    chk({nm, "_lat"},   64'(lat),     64'(lat_x));
    chk({nm, "_res"},   64'(result),  64'(r));
    chk({nm, "_model"}, 64'(m_res),   64'(r));
    chk({nm, "_carry"}, 64'(carry),   64'(c));
    chk({nm, "_zero"},  64'(zero),    64'(z));
    chk({nm, "_err"},   64'(div_err), 64'(e));
    chk({nm, "_ready"}, 64'(ready),   64'd1);
  endtask

  int lat, ndone;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #12;
    chk("rst_ready",  64'(ready),  64'd1);
    chk("rst_done",   64'(done),   64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags",  64'({carry, zero, div_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    go(4'b1111, 4'b1000, 3'd0);
    wait_done(lat);
    expect_res("add", lat, 0, 8'h07, 1'b1, 1'b0, 1'b0);

    go(4'b1111, 4'b1111, 3'd1);
    wait_done(lat);
    expect_res("sub_eq", lat, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    go(4'b0010, 4'b0101, 3'd1);
    wait_done(lat);
    expect_res("sub_brw", lat, 0, 8'h0D, 1'b1, 1'b0, 1'b0);

    go(4'b1001, 4'b1001, 3'd2);
    wait_done(lat);
    expect_res("mul", lat, 4, 8'h51, 1'b0, 1'b0, 1'b0);

    go(4'b1001, 4'b1001, 3'd2);
    ndone = 0;
    start = 1'b1;
    a     = 4'd1;
    b     = 4'd1;
    op    = 3'd0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("busy_ndone", 64'(ndone), 64'd1);
    chk("busy_res",   64'(result), 64'h51);

    go(4'b1010, 4'b0010, 3'd3);
    wait_done(lat);
    expect_res("div", lat, 4, 8'h05, 1'b0, 1'b0, 1'b0);
    issue(4'b1010, 4'b0010, 3'd4);
    wait_done(lat);
    expect_res("mod_b2b", lat, 4, 8'h00, 1'b0, 1'b1, 1'b0);

    go(4'b1000, 4'b0000, 3'd3);
    wait_done(lat);
    expect_res("div0", lat, 0, 8'h0F, 1'b0, 1'b0, 1'b1);

    go(4'b1000, 4'b0000, 3'd4);
    wait_done(lat);
    expect_res("mod0", lat, 0, 8'h08, 1'b0, 1'b0, 1'b1);

    go(4'b1111, 4'b1111, 3'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ready",  64'(ready),  64'd1);
    chk("midrst_done",   64'(done),   64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags",  64'({carry, zero, div_err}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_ndone", 64'(ndone), 64'd0);

    go(4'b0001, 4'b0001, 3'd0);
    wait_done(lat);
    expect_res("add_after", lat, 0, 8'h02, 1'b0, 1'b0, 1'b0);

    repeat (600) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a     = N'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      op    = 3'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Registered, multi-cycle ALU. It is the responder side of the operand/opcode interface that the lab stimulus drives.
- Accepts operands a, b and a 3-bit opcode through a start/ready handshake.
- Add, subtract and logic ops complete in one cycle. Multiply, divide and modulo run iteratively over N cycles.
- Returns a registered result with flags and a one-cycle done pulse. Sits between the operand switch/button front end and the display/result logic.

Parameters:
N, 4, operand width in bits (N >= 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while ready=1
a  input  N  operand A (unsigned)
b  input  N  operand B (unsigned)
op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor
ready  output  1  block can accept start
done  output  1  one-cycle pulse: result/flags valid and newly updated
result  output  2N  result; upper N bits zero except for mul
carry  output  1  add: carry out; sub: borrow (1 when a<b); else 0
zero  output  1  result == 0
div_err  output  1  div/mod with b == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready=1, done=0, result=0, carry=0, zero=0, div_err=0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE: on the edge where start=1, a/b/op are registered and ready falls.
  - Single-cycle ops (add, sub, and, or, xor, or div/mod with b=0) go to DONE.
  - mul, div, mod (b≠0) go to CALC with iteration counter = 0.
- CALC, mul: shift-add multiply, one partial product per cycle over N cycles. The accumulator is 2N bits; the full product is kept (no truncation).
- CALC, div/mod: restoring division, one quotient bit per cycle, MSB first, over N cycles. div returns the quotient in result[N-1:0]; mod returns the remainder.
- CALC exits to DONE after the Nth iteration (counter == N-1).
- DONE: lasts one cycle.
  - result and flags updated on the entry edge; done=1 and ready=1 in this cycle.
  - A start sampled in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise the next state is IDLE.
- Latency, counted from the accepting edge to the cycle with done=1:
  - add, sub, logic, b=0 div/mod: 1 cycle (done high in the cycle after the accept edge).
  - mul, div, mod: N+1 cycles.
- Outputs hold their last values until the next done. done is never high two consecutive cycles unless back-to-back starts are issued.
- start while ready=0 is ignored. Changes on a/b/op after acceptance have no effect.
- Arithmetic rules:
  - add: result = zero-extend (a+b) mod 2^N; carry = bit N.
  - sub: result = (a-b) mod 2^N; carry = borrow.
  - mul: result = a*b (2N bits).
  - Logic ops are bitwise on N bits.
- Divide by zero: div gives result = all ones in N bits; mod gives result = a; div_err=1; 1-cycle latency. div_err=0 for every other case.
- zero is computed on the full 2N-bit result.

Test Plan:
- N=4, add: a=1111, b=1000, op=000, start pulse -> next cycle done=1, result=0x07, carry=1, zero=0, ready=1.
- Sub: a=1111, b=1111, op=001 -> result=0x00, zero=1, carry=0.
- Sub: a=0010, b=0101 -> result=0x0D, carry=1.
- Mul: a=1001, b=1001, op=010 -> ready=0 for 4 cycles, done in 5th cycle, result=0x51.
- A start issued during the mul busy window is ignored and produces no extra done.
- Div/mod: a=1010, b=0010, op=011 -> result=0x05, div_err=0 after 5 cycles.
- Repeat with op=100 issued in the DONE cycle (back-to-back) -> result=0x00, zero=1.
- Div by zero: a=1000, b=0000, op=011 -> 1-cycle done, result=0x0F, div_err=1.
- Same with op=100 -> result=0x08, div_err=1.
- Reset mid-op: start mul a=1111, b=1111, drop rst_n at cycle 2 (asynchronous, off-edge) -> immediately ready=1, result=0, all flags 0, no done after release.
- Then add 0001+0001 -> result=0x02 with 1-cycle latency.
